// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, widths,
// arbiter FSM state encoding and an opcode legality helper.
package alu_pkg;

  localparam int ALU_OP_W = 4;
  localparam int SHAMT_W  = 5;

  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB     = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR      = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD     = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_LUI     = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL     = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL     = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND     = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOR     = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_NOTHING = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } arb_state_e;

  // True for opcodes the ALU actually implements (SUB..NOTHING).
  function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op);
    return (op >= ALU_OP_SUB) && (op <= ALU_OP_NOTHING);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first valid requester at or
// after the pointer, wrapping to the lowest valid one below the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_hi_grant;
  logic [NUM_REQ-1:0] w_lo_grant;
  logic               w_hi_any;
  logic               w_lo_any;
  logic               w_hit_hi;
  logic               w_hit_lo;

  // Two priority scans: one restricted to indices >= pointer, one unrestricted.
  always_comb begin
    w_hi_grant = '0;
    w_lo_grant = '0;
    w_hi_any   = 1'b0;
    w_lo_any   = 1'b0;
    w_hit_hi   = 1'b0;
    w_hit_lo   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_hit_hi      = i_valid[k] && (k >= int'(i_ptr)) && !w_hi_any;
      w_hit_lo      = i_valid[k] && !w_lo_any;
      w_hi_grant[k] = w_hit_hi;
      w_lo_grant[k] = w_hit_lo;
      w_hi_any      = w_hi_any | w_hit_hi;
      w_lo_any      = w_lo_any | w_hit_lo;
    end
  end

  // Prefer the scan above the pointer; encode the one-hot grant as an index.
  always_comb begin
    o_grant = w_hi_any ? w_hi_grant : w_lo_grant;
    o_any   = w_lo_any;
    o_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_idx = o_idx | (ID_W'(k) & {ID_W{o_grant[k]}});
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters. Round-robin grant
// in IDLE, one ISSUE cycle driving the ALU from registered operands, then the
// captured result is held in RESP until the consumer accepts it.
// Optional feature macro: ALU_ILLEGAL_OP_EN (adds rsp_err_o; opcodes outside
// SUB..NOTHING bypass the ALU and return data=0, zero=1, err=1).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [ALU_OP_W*NUM_REQ-1:0] req_op_i,
  input  logic [DATA_W*NUM_REQ-1:0]   req_a_i,
  input  logic [DATA_W*NUM_REQ-1:0]   req_b_i,
  input  logic [SHAMT_W*NUM_REQ-1:0]  req_shamt_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [ID_W-1:0]             rsp_id_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic                        rsp_zero_o,
  output logic [ALU_OP_W-1:0]         alu_operation_o,
  output logic [DATA_W-1:0]           alu_a_o,
  output logic [DATA_W-1:0]           alu_b_o,
  output logic [SHAMT_W-1:0]          alu_shamt_o,
  input  logic [DATA_W-1:0]           alu_data_i,
  input  logic                        alu_zero_i
`ifdef ALU_ILLEGAL_OP_EN
  ,
  output logic                        rsp_err_o
`endif
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_idx;
  logic                w_any;
  logic                w_take;

  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [ID_W-1:0]     r_id;

  logic [ALU_OP_W-1:0] w_sel_op;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [SHAMT_W-1:0]  w_sel_shamt;

  logic [ALU_OP_W-1:0] r_alu_op;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [SHAMT_W-1:0]  r_alu_shamt;

  logic                r_rsp_valid;
  logic [ID_W-1:0]     r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_zero;

`ifdef ALU_ILLEGAL_OP_EN
  logic                r_illegal;
  logic                r_rsp_err;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_valid (req_valid_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_take = (r_state == ST_IDLE) && w_any;

  // One-hot AND-OR mux of the granted requester's fields.
  always_comb begin
    w_sel_op    = '0;
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_sel_shamt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sel_op    = w_sel_op    | (req_op_i[k*ALU_OP_W +: ALU_OP_W]  & {ALU_OP_W{w_grant[k]}});
      w_sel_a     = w_sel_a     | (req_a_i[k*DATA_W +: DATA_W]       & {DATA_W{w_grant[k]}});
      w_sel_b     = w_sel_b     | (req_b_i[k*DATA_W +: DATA_W]       & {DATA_W{w_grant[k]}});
      w_sel_shamt = w_sel_shamt | (req_shamt_i[k*SHAMT_W +: SHAMT_W] & {SHAMT_W{w_grant[k]}});
    end
  end

  // Pointer advances to the requester after the one just granted, with wrap.
  always_comb begin
    if (w_idx == ID_W'(NUM_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_idx + ID_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and the request-side ready (only while IDLE grants).
  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_ISSUE;
          req_ready_o = w_grant;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch pointer, owner id and ALU operands on a grant; hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_shamt <= '0;
`ifdef ALU_ILLEGAL_OP_EN
      r_illegal   <= 1'b0;
`endif
    end else if (w_take) begin
      r_ptr <= w_ptr_nxt;
      r_id  <= w_idx;
`ifdef ALU_ILLEGAL_OP_EN
      // Illegal opcodes never reach the ALU, so its ports keep the last legal op.
      r_illegal <= ~op_is_legal(w_sel_op);
      if (op_is_legal(w_sel_op)) begin
        r_alu_op    <= w_sel_op;
        r_alu_a     <= w_sel_a;
        r_alu_b     <= w_sel_b;
        r_alu_shamt <= w_sel_shamt;
      end
`else
      r_alu_op    <= w_sel_op;
      r_alu_a     <= w_sel_a;
      r_alu_b     <= w_sel_b;
      r_alu_shamt <= w_sel_shamt;
`endif
    end
  end

  // Capture the ALU result at the end of ISSUE and hold it through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
      r_rsp_err   <= 1'b0;
`endif
    end else if (r_state == ST_ISSUE) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
`ifdef ALU_ILLEGAL_OP_EN
      if (r_illegal) begin
        r_rsp_data <= '0;
        r_rsp_zero <= 1'b1;
        r_rsp_err  <= 1'b1;
      end else begin
        r_rsp_data <= alu_data_i;
        r_rsp_zero <= alu_zero_i;
        r_rsp_err  <= 1'b0;
      end
`else
      r_rsp_data  <= alu_data_i;
      r_rsp_zero  <= alu_zero_i;
`endif
    end else if ((r_state == ST_RESP) && rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_id_o        = r_rsp_id;
  assign rsp_data_o      = r_rsp_data;
  assign rsp_zero_o      = r_rsp_zero;
  assign alu_operation_o = r_alu_op;
  assign alu_a_o         = r_alu_a;
  assign alu_b_o         = r_alu_b;
  assign alu_shamt_o     = r_alu_shamt;
`ifdef ALU_ILLEGAL_OP_EN
  assign rsp_err_o       = r_rsp_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with two requesters and a behavioural
// ALU attached to the ALU-side ports.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [4*N-1:0]  req_op;
  logic [DW*N-1:0] req_a;
  logic [DW*N-1:0] req_b;
  logic [5*N-1:0]  req_shamt;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [0:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [4:0]    alu_sh;
  logic [DW-1:0] alu_data;
  logic          alu_zero;
`ifdef ALU_ILLEGAL_OP_EN
  logic          rsp_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ref_ptr  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ID_W(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_op_i        (req_op),
    .req_a_i         (req_a),
    .req_b_i         (req_b),
    .req_shamt_i     (req_shamt),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_id_o        (rsp_id),
    .rsp_data_o      (rsp_data),
    .rsp_zero_o      (rsp_zero),
    .alu_operation_o (alu_op),
    .alu_a_o         (alu_a),
    .alu_b_o         (alu_b),
    .alu_shamt_o     (alu_sh),
    .alu_data_i      (alu_data),
    .alu_zero_i      (alu_zero)
`ifdef ALU_ILLEGAL_OP_EN
    ,
    .rsp_err_o       (rsp_err)
`endif
  );

  // Behavioural ALU: result of an opcode on its operands.
  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [4:0] sh);
    case (op)
      4'b0001: return a - b;
      4'b0010: return a | b;
      4'b0011: return a + b;
      4'b0100: return {b[15:0], 16'h0000};
      4'b0101: return b << sh;
      4'b0110: return b >> sh;
      4'b0111: return a & b;
      4'b1000: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Round-robin rule: first valid index at or after ptr, wrapping around.
  function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  always_comb begin
    alu_data = ref_alu(alu_op, alu_a, alu_b, alu_sh);
    alu_zero = (alu_data == 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [4:0] sh);
    req_op[k*4 +: 4]     = op;
    req_a[k*DW +: DW]    = a;
    req_b[k*DW +: DW]    = b;
    req_shamt[k*5 +: 5]  = sh;
  endtask

  task automatic rand_req(input int k);
    set_req(k, 4'($urandom_range(1, 9)), $urandom, $urandom, 5'($urandom));
  endtask

  // Single-requester transaction with rsp_ready high; returns what was observed.
  task automatic run_op(input int k, input logic [3:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [4:0] sh,
                        output logic [N-1:0] rdy, output logic v, output logic [DW-1:0] d,
                        output logic z, output logic [0:0] id);
    rsp_ready = 1'b1;
    set_req(k, op, a, b, sh);
    req_valid = '0;
    req_valid[k] = 1'b1;
    #1;
    rdy = req_ready;
    step();
    req_valid = '0;
    step();
    v  = rsp_valid;
    d  = rsp_data;
    z  = rsp_zero;
    id = rsp_id;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
    step(); step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    n_checks++; if (alu_op !== 4'b0000) begin n_fail++; $display("FAIL reset_alu_op got %b want 0000", alu_op); end
    n_checks++; if ({alu_a, alu_b, rsp_data} !== 96'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {alu_a, alu_b, rsp_data}); end
    reset = 1'b1;
    ref_ptr = 0;
    step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    set_req(0, 4'b0011, 32'd5, 32'd7, 5'd0);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_ready got %b want 01", req_ready); end
    ref_ptr = (ref_pick(2'b01, ref_ptr) + 1) % N;
    step();
    req_valid = 2'b00;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL add_ready_pulse got %b want 00", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid got %b want 0", rsp_valid); end
    n_checks++; if ({alu_op, alu_a, alu_b} !== {4'b0011, 32'd5, 32'd7}) begin n_fail++; $display("FAIL add_alu_ports got %h want %h", {alu_op, alu_a, alu_b}, {4'b0011, 32'd5, 32'd7}); end
    step();
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", rsp_valid); end
    n_checks++; if ({rsp_data, rsp_zero, rsp_id} !== {32'd12, 1'b0, 1'b0}) begin n_fail++; $display("FAIL add_rsp got %h/%b/%0d want 12/0/0", rsp_data, rsp_zero, rsp_id); end
    step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_drop got %b want 0", rsp_valid); end
  endtask

  task automatic test_stall();
    rsp_ready = 1'b0;
    set_req(0, 4'b0001, 32'd9, 32'd9, 5'd0);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_ready got %b want 01", req_ready); end
    ref_ptr = (ref_pick(2'b01, ref_ptr) + 1) % N;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({rsp_valid, rsp_data, rsp_zero, rsp_id} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL stall_hold[%0d] got %b/%h/%b/%0d want 1/0/1/0", i, rsp_valid, rsp_data, rsp_zero, rsp_id); end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_no_grant[%0d] got %b want 00", i, req_ready); end
      if (i == 3) begin
        rsp_ready = 1'b1;
        req_valid = 2'b00;
      end
      step();
    end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b want 0", rsp_valid); end
  endtask

  task automatic test_shifts();
    logic [N-1:0] rdy; logic v; logic [DW-1:0] d; logic z; logic [0:0] id;
    run_op(1, 4'b0101, 32'd0, 32'd1, 5'd4, rdy, v, d, z, id);
    ref_ptr = 0;
    n_checks++; if ({rdy, v, d, z, id} !== {2'b10, 1'b1, 32'd16, 1'b0, 1'b1}) begin n_fail++; $display("FAIL sll got %b/%b/%h/%b/%0d want 10/1/10/0/1", rdy, v, d, z, id); end
    run_op(0, 4'b0100, 32'd0, 32'h0000ABCD, 5'd0, rdy, v, d, z, id);
    ref_ptr = 1;
    n_checks++; if ({rdy, v, d, z, id} !== {2'b01, 1'b1, 32'hABCD0000, 1'b0, 1'b0}) begin n_fail++; $display("FAIL lui got %b/%b/%h/%b/%0d want 01/1/abcd0000/0/0", rdy, v, d, z, id); end
  endtask

  task automatic test_back_to_back();
    int exp_k; logic [N-1:0] exp_rdy; logic [DW-1:0] exp_d;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int it = 0; it < 12; it++) begin
      rand_req(0); rand_req(1);
      #1;
      exp_k = ref_pick(2'b11, ref_ptr);
      exp_rdy = '0; exp_rdy[exp_k] = 1'b1;
      exp_d = ref_alu(req_op[exp_k*4 +: 4], req_a[exp_k*DW +: DW], req_b[exp_k*DW +: DW], req_shamt[exp_k*5 +: 5]);
      ref_ptr = (exp_k + 1) % N;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_grant[%0d] got %b want %b", it, req_ready, exp_rdy); end
      step();
      rand_req(0); rand_req(1);
      #1;
      n_checks++; if ({req_ready, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL b2b_issue[%0d] got %b/%b want 00/0", it, req_ready, rsp_valid); end
      step();
      n_checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_zero} !== {1'b1, 1'(exp_k), exp_d, (exp_d == 32'd0)}) begin n_fail++; $display("FAIL b2b_rsp[%0d] got %b/%0d/%h/%b want 1/%0d/%h/%b", it, rsp_valid, rsp_id, rsp_data, rsp_zero, exp_k, exp_d, (exp_d == 32'd0)); end
      step();
    end
    req_valid = 2'b00;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", rsp_valid); end
  endtask

  task automatic test_random();
    logic [N-1:0] v; int exp_k; logic [N-1:0] exp_rdy; logic [DW-1:0] exp_d; int stall;
    for (int it = 0; it < 30; it++) begin
      v = 2'($urandom_range(0, 3));
      rand_req(0); rand_req(1);
      req_valid = v;
      rsp_ready = 1'b1;
      #1;
      exp_k = ref_pick(v, ref_ptr);
      exp_rdy = '0;
      if (exp_k >= 0) exp_rdy[exp_k] = 1'b1;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_grant[%0d] got %b want %b", it, req_ready, exp_rdy); end
      if (exp_k < 0) begin
        step();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle[%0d] got %b want 0", it, rsp_valid); end
      end else begin
        exp_d = ref_alu(req_op[exp_k*4 +: 4], req_a[exp_k*DW +: DW], req_b[exp_k*DW +: DW], req_shamt[exp_k*5 +: 5]);
        ref_ptr = (exp_k + 1) % N;
        step();
        req_valid = 2'($urandom_range(0, 3));
        rand_req(0); rand_req(1);
        step();
        stall = $urandom_range(0, 2);
        for (int s = 0; s <= stall; s++) begin
          rsp_ready = (s == stall);
          n_checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_zero} !== {1'b1, 1'(exp_k), exp_d, (exp_d == 32'd0)}) begin n_fail++; $display("FAIL rnd_rsp[%0d.%0d] got %b/%0d/%h/%b want 1/%0d/%h/%b", it, s, rsp_valid, rsp_id, rsp_data, rsp_zero, exp_k, exp_d, (exp_d == 32'd0)); end
          step();
        end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drop[%0d] got %b want 0", it, rsp_valid); end
      end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    rsp_ready = 1'b1;
    set_req(1, 4'b0011, 32'd3, 32'd4, 5'd0);
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rst_mid_grant got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    reset = 1'b0;
    #1;
    n_checks++; if ({rsp_valid, alu_op, alu_a} !== {1'b0, 4'b0000, 32'd0}) begin n_fail++; $display("FAIL rst_mid_clear got %b/%b/%h want 0/0000/0", rsp_valid, alu_op, alu_a); end
    step(); step();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold got %b want 0", rsp_valid); end
    reset = 1'b1;
    ref_ptr = 0;
    set_req(0, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    set_req(1, 4'b0010, 32'd1, 32'd2, 5'd0);
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_mid_first got %b want 01", req_ready); end
    ref_ptr = 1;
    step();
    req_valid = 2'b00;
    step();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'hF000F000}) begin n_fail++; $display("FAIL rst_mid_rsp got %b/%0d/%h want 1/0/f000f000", rsp_valid, rsp_id, rsp_data); end
    step();
  endtask

`ifdef ALU_ILLEGAL_OP_EN
  task automatic test_illegal_op();
    logic [N-1:0] rdy; logic v; logic [DW-1:0] d; logic z; logic [0:0] id;
    rsp_ready = 1'b1;
    set_req(0, 4'b1111, 32'd5, 32'd6, 5'd0);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ill_grant got %b want 01", req_ready); end
    ref_ptr = 1;
    step();
    req_valid = 2'b00;
    step();
    n_checks++; if ({rsp_valid, rsp_err, rsp_data, rsp_zero} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin n_fail++; $display("FAIL ill_rsp got %b/%b/%h/%b want 1/1/0/1", rsp_valid, rsp_err, rsp_data, rsp_zero); end
    step();
    run_op(0, 4'b0011, 32'd1, 32'd1, 5'd0, rdy, v, d, z, id);
    ref_ptr = 1;
    n_checks++; if ({v, rsp_err, d, z} !== {1'b1, 1'b0, 32'd2, 1'b0}) begin n_fail++; $display("FAIL ill_next_add got %b/%b/%h/%b want 1/0/2/0", v, rsp_err, d, z); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_stall();
    test_shifts();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
`ifdef ALU_ILLEGAL_OP_EN
    test_illegal_op();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
